sti_pack_tx: RTL and testbench
==============================

STI_PACK_TX -- requirements
Module: sti_pack_tx

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- DATA_W, 16, pi_data width; even; DATA_W/2 is a multiple of PIX_W.
- PIX_W, 8, bits per packed pixel.
- ADDR_W, 8, pixel address width; the pixel store holds 2^ADDR_W words.

REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, clock; all state changes on the rising edge.
- reset, in, 1, synchronous, active-high.
- load, in, 1, word-accept request.
- pi_data, in, DATA_W, word payload.
- pi_length, in, 2, word length select.
- pi_fill, in, 1, alignment for long words.
- pi_msb, in, 1, 1 = MSB first, 0 = LSB first.
- pi_low, in, 1, half-word select.
- pi_end, in, 1, end-of-stream request.
- pi_ready, out, 1, block can accept load or pi_end.
- so_data, out, 1, serial bit.
- so_valid, out, 1, so_data qualifier.
- pixel_wr, out, 1, pixel write strobe.
- pixel_addr, out, ADDR_W, pixel write address.
- pixel_dataout, out, PIX_W, pixel write data.
- pixel_finish, out, 1, sticky completion flag.

Function
REQ-003 States: IDLE, SHIFT, PAD, DONE; pi_ready = (state==IDLE), combinational.
REQ-004 load is accepted only when load=1 and pi_ready=1; pi_data, pi_length, pi_fill, pi_msb and pi_low are captured on the accept edge, and the inputs may change afterwards.
REQ-005 Word length is L = (pi_length+1)*DATA_W/2.
REQ-006 Word construction by length:
- L=DATA_W/2: word is pi_data upper half when pi_low=0, lower half when pi_low=1.
- L=DATA_W: word is pi_data.
- L>DATA_W, pi_fill=1: pi_data in the MSBs, zeros below.
- L>DATA_W, pi_fill=0: zeros above, pi_data right-aligned.
REQ-007 Accept on edge k: IDLE->SHIFT; so_valid=1 for exactly L consecutive cycles starting at k+1; bit order per captured pi_msb; state returns to IDLE on the edge ending the last bit.
REQ-008 so_data is 0 whenever so_valid=0.
REQ-009 Pixel packing:
- Every transmitted bit is packed into the pixel accumulator; the first bit of each PIX_W group lands in the pixel MSB.
- The bit counter persists across words; a pixel may not straddle words because L is a multiple of PIX_W.
REQ-010 Pixel write timing:
- pixel_wr pulses for one cycle, in the same cycle so_valid carries the PIX_W-th bit of the group.
- pixel_dataout holds the complete pixel and pixel_addr holds its target address during that cycle.
- pixel_addr increments by 1 on the following edge.
REQ-011 pi_end accepted in IDLE moves the block to PAD; when load and pi_end are both high in the same cycle, pi_end wins and load is ignored.
REQ-012 PAD writes one pixel per cycle with pixel_wr=1 and pixel_dataout=0, from the current pixel_addr through 2^ADDR_W-1.
REQ-013 A write to address 2^ADDR_W-1 in any state behaves as follows:
- pixel_finish is set on the following edge and stays high until reset.
- Subsequent pixel writes are suppressed and pixel_addr holds (no wrap).
- An in-progress SHIFT completes its serial bits, then the state goes to DONE; PAD goes to DONE directly.
REQ-014 DONE: pi_ready=0, load and pi_end ignored, so_valid=0, pixel_wr=0.
REQ-015 pi_end in PAD or DONE has no effect; load in SHIFT, PAD or DONE has no effect and is not queued.

Reset
REQ-016 Reset values: state IDLE, so_data 0, so_valid 0, pixel_wr 0, pixel_addr 0, pixel_dataout 0, pixel_finish 0, pixel bit counter 0.
- pi_ready is 1 from the first cycle after reset deasserts.
REQ-017 Reset asserted in any state, including mid-SHIFT or PAD, forces all REQ-016 values on the next edge and discards any partial pixel.

Verification (DATA_W=16, PIX_W=8, ADDR_W=8)
REQ-018 Half word, high half:
- Stimulus: load with 0xA53C, length 0, pi_low=0, pi_msb=1.
- Response: so_data 1,0,1,0,0,1,0,1 in cycles k+1..k+8; pixel_wr at k+8 with dataout 0xA5, addr 0.
REQ-019 Long word, right-aligned, LSB first:
- Stimulus: load with 0x1234, length 3, fill 0, msb 0.
- Response: 32 valid bits; pixels 0x2C, 0x48, 0x00, 0x00 at addrs 0..3.
REQ-020 Long word, MSB-aligned, MSB first:
- Stimulus: load with 0xBEEF, length 2, fill 1, msb 1.
- Response: 24 bits; pixels 0xBE, 0xEF, 0x00 at consecutive addresses.
REQ-021 End of stream:
- Stimulus: pi_end after 3 pixels written.
- Response: 253 consecutive zero writes at addrs 3..255; pixel_finish high one cycle after the addr-255 write; pi_ready 0 and load ignored thereafter.
REQ-022 Handshake and reset:
- load while pi_ready=0 produces no extra bits.
- load with pi_end in the same cycle enters PAD.
- reset mid-SHIFT gives all outputs 0 and pi_ready 1 on the next cycle, and a new load then writes addr 0.

Source files
------------

// File: rtl/sti_pack_tx.sv
// sti_pack_tx: serialises loaded words onto so_data and packs the same bits
// into PIX_W-bit pixels written sequentially to a 2^ADDR_W-word pixel store.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   load, pi_*        word request, payload, length, alignment, bit order,
//                     half select; pi_end requests end-of-stream padding
//   pi_ready          block is idle and can take load or pi_end
//   so_data/so_valid  serial bit and its qualifier
//   pixel_*           pixel write strobe, address, data, sticky finish flag
module sti_pack_tx #(
    parameter int DATA_W = 16,
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] pi_data,
    input  logic [1:0]        pi_length,
    input  logic              pi_fill,
    input  logic              pi_msb,
    input  logic              pi_low,
    input  logic              pi_end,
    output logic              pi_ready,
    output logic              so_data,
    output logic              so_valid,
    output logic              pixel_wr,
    output logic [ADDR_W-1:0] pixel_addr,
    output logic [PIX_W-1:0]  pixel_dataout,
    output logic              pixel_finish
);

    localparam int HALF = DATA_W / 2;
    localparam int SW   = 2 * DATA_W;
    localparam int CW   = $clog2(SW) + 1;
    localparam int PCW  = (PIX_W > 1) ? $clog2(PIX_W) : 1;

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    localparam logic [PCW-1:0]    PIX_LAST = PCW'(PIX_W - 1);
    localparam logic [HALF-1:0]   ZH       = '0;
    localparam logic [DATA_W-1:0] ZD       = '0;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_PAD   = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]       r_state;
    logic [SW-1:0]    r_sh;
    logic             r_msb;
    logic [CW-1:0]    r_rem;
    logic [PIX_W-2:0] r_pix;
    logic [PCW-1:0]   r_cnt;

    logic             w_accept;
    logic             w_end_acc;
    logic [HALF-1:0]  w_half;
    logic [SW-1:0]    w_right;
    logic [SW-1:0]    w_left;
    logic [CW-1:0]    w_len;
    logic             w_emit;
    logic             w_bit;
    logic [PIX_W-1:0] w_pix_next;
    logic             w_grp_done;
    logic             w_last_wr;
    logic             w_stop;

    assign pi_ready  = (r_state == ST_IDLE);
    assign w_end_acc = pi_end && pi_ready;
    assign w_accept  = load && pi_ready && !pi_end;

    // Word built twice: right-aligned (LSB-first shifts out bit 0) and
    // left-aligned (MSB-first shifts out the top bit of the SW register).
    always_comb begin
        w_half  = pi_low ? pi_data[HALF-1:0] : pi_data[DATA_W-1:HALF];
        w_right = '0;
        w_left  = '0;
        w_len   = CW'(HALF);
        case (pi_length)
            2'd0: begin
                w_right = {ZD, ZH, w_half};
                w_left  = {w_half, ZH, ZD};
                w_len   = CW'(HALF);
            end
            2'd1: begin
                w_right = {ZD, pi_data};
                w_left  = {pi_data, ZD};
                w_len   = CW'(DATA_W);
            end
            2'd2: begin
                w_len = CW'(3 * HALF);
                if (pi_fill) begin
                    w_right = {ZH, pi_data, ZH};
                    w_left  = {pi_data, ZD};
                end else begin
                    w_right = {ZD, pi_data};
                    w_left  = {ZH, pi_data, ZH};
                end
            end
            default: begin
                w_len = CW'(SW);
                if (pi_fill) begin
                    w_right = {pi_data, ZD};
                    w_left  = {pi_data, ZD};
                end else begin
                    w_right = {ZD, pi_data};
                    w_left  = {ZD, pi_data};
                end
            end
        endcase
    end

    // The first bit leaves on the accept edge; the rest follow from r_sh.
    always_comb begin
        w_emit = 1'b0;
        w_bit  = 1'b0;
        if (w_accept) begin
            w_emit = 1'b1;
            w_bit  = pi_msb ? w_left[SW-1] : w_right[0];
        end else if (r_state == ST_SHIFT && r_rem != '0) begin
            w_emit = 1'b1;
            w_bit  = r_msb ? r_sh[SW-1] : r_sh[0];
        end
    end

    assign w_pix_next = {r_pix, w_bit};
    assign w_grp_done = w_emit && (r_cnt == PIX_LAST);
    // The write to the last address is the final one; anything after it
    // (including the edge that ends that write cycle) is suppressed.
    assign w_last_wr  = pixel_wr && (pixel_addr == ADDR_MAX);
    assign w_stop     = pixel_finish || w_last_wr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_sh          <= '0;
            r_msb         <= 1'b0;
            r_rem         <= '0;
            r_pix         <= '0;
            r_cnt         <= '0;
            so_data       <= 1'b0;
            so_valid      <= 1'b0;
            pixel_wr      <= 1'b0;
            pixel_addr    <= '0;
            pixel_dataout <= '0;
            pixel_finish  <= 1'b0;
        end else begin
            so_valid <= w_emit;
            so_data  <= w_emit & w_bit;
            pixel_wr <= 1'b0;

            if (w_emit) begin
                r_pix <= w_pix_next[PIX_W-2:0];
                r_cnt <= w_grp_done ? '0 : r_cnt + 1'b1;
                if (w_grp_done && !w_stop) begin
                    pixel_wr      <= 1'b1;
                    pixel_dataout <= w_pix_next;
                end
            end

            if (pixel_wr && pixel_addr != ADDR_MAX) begin
                pixel_addr <= pixel_addr + 1'b1;
            end
            if (w_last_wr) begin
                pixel_finish <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_end_acc) begin
                        r_state <= ST_PAD;
                        if (!w_stop) begin
                            pixel_wr      <= 1'b1;
                            pixel_dataout <= '0;
                        end
                    end else if (w_accept) begin
                        r_state <= ST_SHIFT;
                        r_msb   <= pi_msb;
                        r_rem   <= w_len - CW'(1);
                        r_sh    <= pi_msb ? (w_left << 1)
                                          : (w_right >> 1);
                    end
                end
                ST_SHIFT: begin
                    if (r_rem != '0) begin
                        r_rem <= r_rem - 1'b1;
                        r_sh  <= r_msb ? (r_sh << 1) : (r_sh >> 1);
                    end else begin
                        r_state <= w_stop ? ST_DONE : ST_IDLE;
                    end
                end
                ST_PAD: begin
                    if (w_stop) begin
                        r_state <= ST_DONE;
                    end else begin
                        pixel_wr      <= 1'b1;
                        pixel_dataout <= '0;
                    end
                end
                default: begin
                    r_state <= ST_DONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sti_pack_tx.sv
// tb_sti_pack_tx: directed and randomized bench for sti_pack_tx; a bit-stream
// level model predicts every serial bit and pixel write cycle by cycle.
module tb_sti_pack_tx;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [15:0] pi_data;
    logic [1:0]  pi_length;
    logic        pi_fill;
    logic        pi_msb;
    logic        pi_low;
    logic        pi_end;
    logic        pi_ready;
    logic        so_data;
    logic        so_valid;
    logic        pixel_wr;
    logic [7:0]  pixel_addr;
    logic [7:0]  pixel_dataout;
    logic        pixel_finish;

    int total = 0;
    int bad   = 0;

    int         maddr;
    int         mcnt;
    logic [7:0] mpix;
    bit         mfin;
    logic [7:0] obs [256];

    sti_pack_tx #(.DATA_W(16), .PIX_W(8), .ADDR_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .load         (load),
        .pi_data      (pi_data),
        .pi_length    (pi_length),
        .pi_fill      (pi_fill),
        .pi_msb       (pi_msb),
        .pi_low       (pi_low),
        .pi_end       (pi_end),
        .pi_ready     (pi_ready),
        .so_data      (so_data),
        .so_valid     (so_valid),
        .pixel_wr     (pixel_wr),
        .pixel_addr   (pixel_addr),
        .pixel_dataout(pixel_dataout),
        .pixel_finish (pixel_finish)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Word as an L-bit value, straight from the length/fill/half rules.
    function automatic logic [63:0] mk_word(input logic [15:0] d,
                                            input int len, input bit fill,
                                            input bit low);
        int L;
        logic [63:0] w;
        L = (len + 1) * 8;
        w = 64'(d);
        if (L == 8) return low ? (w & 64'hFF) : (w >> 8);
        if (L == 16) return w;
        return fill ? (w << (L - 16)) : w;
    endfunction

    task automatic model_reset();
        maddr = 0;
        mcnt  = 0;
        mpix  = 8'h00;
        mfin  = 1'b0;
        for (int i = 0; i < 256; i++) obs[i] = 8'hEE;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_valid"}, so_valid, 0);
        chk({tag, "_data"}, so_data, 0);
        chk({tag, "_wr"}, pixel_wr, 0);
        chk({tag, "_addr"}, pixel_addr, 0);
        chk({tag, "_dout"}, pixel_dataout, 0);
        chk({tag, "_fin"}, pixel_finish, 0);
        chk({tag, "_ready"}, pi_ready, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset  = 1'b1;
        load   = 1'b0;
        pi_end = 1'b0;
        @(negedge clk);
        chk_reset_state("rst");
        reset = 1'b0;
        model_reset();
    endtask

    task automatic send_word(input logic [15:0] d, input int len,
                             input bit fill, input bit low, input bit msb);
        logic [63:0] w;
        int L;
        bit b;
        w = mk_word(d, len, fill, low);
        L = (len + 1) * 8;
        @(negedge clk);
        chk("idle_ready", pi_ready, 1);
        load      = 1'b1;
        pi_end    = 1'b0;
        pi_data   = d;
        pi_length = 2'(len);
        pi_fill   = fill;
        pi_low    = low;
        pi_msb    = msb;
        @(negedge clk);
        load      = 1'b0;
        pi_data   = 16'($urandom);
        pi_length = 2'($urandom);
        pi_fill   = 1'($urandom);
        pi_low    = 1'($urandom);
        pi_msb    = 1'($urandom);
        for (int i = 0; i < L; i++) begin
            b = msb ? w[L - 1 - i] : w[i];
            chk("so_valid", so_valid, 1);
            chk("so_data", so_data, b);
            chk("busy", pi_ready, 0);
            chk("finish", pixel_finish, mfin);
            chk("addr", pixel_addr, maddr);
            mpix = {mpix[6:0], b};
            mcnt++;
            if (mcnt == 8 && !mfin) begin
                mcnt = 0;
                chk("pix_wr", pixel_wr, 1);
                chk("pix_dout", pixel_dataout, mpix);
                obs[maddr] = pixel_dataout;
                if (maddr == 255) mfin = 1'b1;
                else maddr++;
            end else begin
                if (mcnt == 8) mcnt = 0;
                chk("no_wr", pixel_wr, 0);
            end
            load    = 1'($urandom);
            pi_data = 16'($urandom);
            @(negedge clk);
        end
        load = 1'b0;
        chk("tail_valid", so_valid, 0);
        chk("tail_data", so_data, 0);
        chk("tail_wr", pixel_wr, 0);
        chk("tail_ready", pi_ready, !mfin);
        chk("tail_fin", pixel_finish, mfin);
    endtask

    task automatic do_end(input bit with_load);
        @(negedge clk);
        chk("end_ready", pi_ready, 1);
        pi_end  = 1'b1;
        load    = with_load;
        pi_data = 16'($urandom);
        @(negedge clk);
        pi_end = 1'b0;
        load   = 1'b0;
        for (int a = maddr; a < 256; a++) begin
            chk("pad_wr", pixel_wr, 1);
            chk("pad_addr", pixel_addr, a);
            chk("pad_dout", pixel_dataout, 0);
            chk("pad_valid", so_valid, 0);
            chk("pad_fin", pixel_finish, 0);
            chk("pad_ready", pi_ready, 0);
            pi_end = 1'($urandom);
            load   = 1'($urandom);
            @(negedge clk);
        end
        maddr = 255;
        mfin  = 1'b1;
        chk("end_fin", pixel_finish, 1);
        chk("end_wr", pixel_wr, 0);
        chk("end_ready0", pi_ready, 0);
        chk("end_addr", pixel_addr, 255);
    endtask

    task automatic done_hold(input int n);
        for (int i = 0; i < n; i++) begin
            load   = 1'($urandom);
            pi_end = 1'($urandom);
            @(negedge clk);
            chk("done_valid", so_valid, 0);
            chk("done_wr", pixel_wr, 0);
            chk("done_ready", pi_ready, 0);
            chk("done_fin", pixel_finish, 1);
            chk("done_addr", pixel_addr, 255);
        end
        load   = 1'b0;
        pi_end = 1'b0;
    endtask

    initial begin
        int n;
        reset     = 1'b1;
        load      = 1'b0;
        pi_end    = 1'b0;
        pi_data   = 16'h0;
        pi_length = 2'd0;
        pi_fill   = 1'b0;
        pi_msb    = 1'b0;
        pi_low    = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk_reset_state("por");
        reset = 1'b0;

        send_word(16'hA53C, 0, 1'b0, 1'b0, 1'b1);
        chk("half_pix", obs[0], 8'hA5);

        do_reset();
        send_word(16'h1234, 3, 1'b0, 1'b0, 1'b0);
        chk("long_p0", obs[0], 8'h2C);
        chk("long_p1", obs[1], 8'h48);
        chk("long_p2", obs[2], 8'h00);
        chk("long_p3", obs[3], 8'h00);
        send_word(16'hBEEF, 2, 1'b1, 1'b0, 1'b1);
        chk("fill_p4", obs[4], 8'hBE);
        chk("fill_p5", obs[5], 8'hEF);
        chk("fill_p6", obs[6], 8'h00);

        do_reset();
        send_word(16'h1234, 2, 1'b0, 1'b0, 1'b1);
        do_end(1'b1);
        done_hold(6);

        do_reset();
        @(negedge clk);
        load      = 1'b1;
        pi_data   = 16'hFFFF;
        pi_length = 2'd3;
        pi_msb    = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_valid", so_valid, 1);
        reset = 1'b1;
        @(negedge clk);
        chk_reset_state("midrst");
        reset = 1'b0;
        model_reset();
        send_word(16'h5AC3, 0, 1'b0, 1'b1, 1'b0);
        chk("post_rst_pix", obs[0], 8'hC3);

        do_reset();
        n = 0;
        while (!mfin && n < 600) begin
            send_word(16'($urandom), int'($urandom_range(0, 3)),
                      1'($urandom), 1'($urandom), 1'($urandom));
            n++;
        end
        chk("fin_reached", pixel_finish, 1);
        done_hold(4);

        do_reset();
        n = int'($urandom_range(2, 6));
        for (int i = 0; i < n; i++) begin
            send_word(16'($urandom), int'($urandom_range(0, 3)),
                      1'($urandom), 1'($urandom), 1'($urandom));
        end
        do_end(1'($urandom));
        done_hold(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
